distinguish_pulse_gen: RTL and testbench
========================================

DISTINGUISH_PULSE_GEN -- requirements
Module: distinguish_pulse_gen

Interface
REQ-001 Parameter WINDOW_CYCLES, default 1000, SHALL set the gate window length in clk cycles (1 ms at 1 MHz).
REQ-002 Parameter SPACING, default 50, SHALL set the cycle distance between consecutive cmp pulse starts.
REQ-003 Parameter PULSE_WIDTH, default 1, SHALL set the cmp_out high time in cycles.
REQ-004 clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  level; high = generator running, low = idle.
REQ-007 load  input  1  one-cycle strobe; captures code_in into the pending register.
REQ-008 code_in  input  4  requested pulse count per window, 0..15.
REQ-009 cmp_out  output  1  pulse train; one pulse per counted event for the downstream distinguish counter.
REQ-010 set_out  output  1  one-cycle window-boundary strobe for the downstream counter's set input.
REQ-011 code_act  output  4  code being transmitted in the current window.
REQ-012 busy  output  1  high while en is high and the window counter is running.

Function
REQ-013 Elaboration SHALL fail unless 15*SPACING < WINDOW_CYCLES, 1 <= PULSE_WIDTH < SPACING, and WINDOW_CYCLES >= 2.
REQ-014 win_cnt SHALL count 0..WINDOW_CYCLES-1 while en=1, wrap to 0, and be held at 0 while en=0.
REQ-015 set_out SHALL be 1 exactly when en=1 and win_cnt==WINDOW_CYCLES-1.
REQ-016 cmp_out SHALL be 1 when en=1, win_cnt in [k*SPACING, k*SPACING+PULSE_WIDTH-1] for some k in 0..code_act-1; otherwise 0.
REQ-017 code_act=0 SHALL produce no cmp pulses; set_out SHALL still fire every window.
REQ-018 load SHALL write code_in to pending in the same cycle; the last load before a boundary wins.
REQ-019 code_act SHALL take the value of pending only at the edge where win_cnt wraps from WINDOW_CYCLES-1 to 0, or at the edge where en rises from 0 to 1.
REQ-020 A load in the same cycle as the wrap SHALL be used by the new window (code_in is forwarded).
REQ-021 The state machine SHALL have the states IDLE (en=0), PULSE (cmp_out high), GAP (between pulses), and TAIL (all pulses sent, waiting for the boundary).
REQ-022 IDLE->PULSE on en rise with a nonzero code, or IDLE->TAIL with a zero code.
REQ-023 PULSE->GAP after PULSE_WIDTH cycles.
REQ-024 GAP->PULSE at the next k*SPACING while pulses remain; otherwise GAP->TAIL.
REQ-025 TAIL->PULSE at the wrap if the new code is nonzero, otherwise TAIL->TAIL.
REQ-026 From any state, en=0 SHALL force IDLE on the next edge; cmp_out, set_out and busy SHALL be 0 in that cycle, and the partial window is discarded.
REQ-027 The pulse counter SHALL be 4 bits and win_cnt SHALL be $clog2(WINDOW_CYCLES) bits; no counter may overflow for legal parameters.
REQ-028 All outputs SHALL be registered; the output latency from win_cnt to the outputs is 0 cycles, meaning the decode is registered against the next count.

Reset
REQ-029 While rst_n=0, cmp_out, set_out and busy SHALL be 0, code_act and pending SHALL be 0, win_cnt SHALL be 0, and state SHALL be IDLE, immediately and without a clock.
REQ-030 Release of rst_n mid-operation SHALL restart from IDLE; the first window begins on the first edge with en=1.

Structure
REQ-031 The state encoding and the default WINDOW_CYCLES, SPACING and PULSE_WIDTH constants SHALL live in the shared distinguish package, which is also used by the distinguish counter.
REQ-032 The window timebase (win_cnt, wrap and set strobe) SHALL be a sub-module named window_timer; the pulse FSM stays in the top module.

Verification
REQ-033 Scenario: reset, load code 5, en=1 -> 5 cmp pulses starting at win_cnt 0, 50, 100, 150, 200, and set_out at cycle 999.
REQ-034 Scenario: code 15 -> last pulse starts at win_cnt 700; exactly 15 pulses per window over 3 windows.
REQ-035 Scenario: code 0 -> cmp_out stays 0 for 3000 cycles; set_out fires at cycles 999, 1999 and 2999.
REQ-036 Scenario: load 3 at cycle 400 of a code-7 window -> that window still emits 7 pulses, the next emits 3, and code_act changes at cycle 1000.
REQ-037 Scenario: load 9 in the wrap cycle -> the next window emits 9 pulses.
REQ-038 Scenario: en=0 at cycle 120 of a code-6 window, then en=1 -> all outputs are 0 while en is low, and the restart emits 6 pulses from win_cnt 0. Also assert rst_n mid-pulse -> cmp_out drops to 0 asynchronously.

Source files
------------

// File: rtl/distinguish_pulse_gen_pkg.sv
// rtl/distinguish_pulse_gen_pkg.sv - shared distinguish state encoding and default timing constants
package distinguish_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_TAIL  = 2'd3
  } pg_state_e;

  localparam int DEF_WINDOW_CYCLES = 1000;
  localparam int DEF_SPACING       = 50;
  localparam int DEF_PULSE_WIDTH   = 1;
  localparam int CODE_W            = 4;

endpackage

// File: rtl/distinguish_pulse_gen_if.sv
// rtl/distinguish_pulse_gen_if.sv - control and pulse-train signals of the distinguish pulse generator
interface distinguish_pulse_gen_if;
  logic       en;
  logic       load;
  logic [3:0] code_in;
  logic       cmp_out;
  logic       set_out;
  logic [3:0] code_act;
  logic       busy;

  modport master (output en, load, code_in, input cmp_out, set_out, code_act, busy);
  modport slave  (input en, load, code_in, output cmp_out, set_out, code_act, busy);
endinterface

// File: rtl/distinguish_pulse_gen_window_timer.sv
// rtl/distinguish_pulse_gen_window_timer.sv - window timebase: win_cnt, window-start flag and set strobe
module window_timer
  import distinguish_pulse_gen_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic win_start,
  output logic set_out,
  output logic busy
);

  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam logic [WW-1:0] W_LAST = WW'(WINDOW_CYCLES - 1);

  logic [WW-1:0] win_cnt;
  logic [WW-1:0] win_nxt;
  logic          at_last;

  assign at_last = (win_cnt == W_LAST);
  // busy doubles as "was running": a fresh en rise restarts the window at 0
  assign win_start = en && (!busy || at_last);

  always_comb begin
    win_nxt = '0;
    if (en && busy && !at_last) win_nxt = win_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
      set_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      win_cnt <= win_nxt;
      set_out <= en && (win_nxt == W_LAST);
      busy    <= en;
    end
  end

endmodule

// File: rtl/distinguish_pulse_gen.sv
// rtl/distinguish_pulse_gen.sv - emits code_act cmp pulses per gate window plus a window-boundary set strobe
module distinguish_pulse_gen
  import distinguish_pulse_gen_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int SPACING       = DEF_SPACING,
  parameter int PULSE_WIDTH   = DEF_PULSE_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  distinguish_pulse_gen_if.slave  bus
);

  if (!((15 * SPACING < WINDOW_CYCLES) && (PULSE_WIDTH >= 1) &&
        (PULSE_WIDTH < SPACING) && (WINDOW_CYCLES >= 2))) begin : g_param_check
    $error("distinguish_pulse_gen: illegal WINDOW_CYCLES/SPACING/PULSE_WIDTH");
  end

  localparam int SPW = $clog2(SPACING);
  localparam logic [SPW-1:0] SP_LAST = SPW'(SPACING - 1);
  localparam logic [SPW-1:0] PW_LAST = SPW'(PULSE_WIDTH - 1);

  pg_state_e     state, state_nxt;
  logic [3:0]    pcnt, pcnt_nxt;
  logic [3:0]    code_act, code_nxt;
  logic [3:0]    pending, pend_nxt;
  logic [SPW-1:0] sp_cnt, sp_nxt;
  logic          cmp_q, cmp_nxt;
  logic          win_start, set_q, busy_q;

  window_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (bus.en),
    .win_start (win_start),
    .set_out   (set_q),
    .busy      (busy_q)
  );

  // forwarding lets a load in the wrap cycle feed the new window directly
  assign pend_nxt = bus.load ? bus.code_in : pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pcnt     <= '0;
      sp_cnt   <= '0;
      code_act <= '0;
      pending  <= '0;
      cmp_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      pcnt     <= pcnt_nxt;
      sp_cnt   <= sp_nxt;
      code_act <= code_nxt;
      pending  <= pend_nxt;
      cmp_q    <= cmp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    sp_nxt    = sp_cnt;
    code_nxt  = code_act;
    if (!bus.en) begin
      state_nxt = ST_IDLE;
      pcnt_nxt  = '0;
      sp_nxt    = '0;
    end else if (win_start) begin
      code_nxt = pend_nxt;
      sp_nxt   = '0;
      if (pend_nxt != 4'd0) begin
        state_nxt = ST_PULSE;
        pcnt_nxt  = 4'd1;
      end else begin
        state_nxt = ST_TAIL;
        pcnt_nxt  = '0;
      end
    end else begin
      case (state)
        ST_PULSE: begin
          sp_nxt = sp_cnt + 1'b1;
          if (sp_cnt == PW_LAST) state_nxt = ST_GAP;
        end
        ST_GAP: begin
          // sp_cnt tracks the offset from the latest pulse start, so the
          // next start lands exactly on k*SPACING
          if (sp_cnt == SP_LAST) begin
            sp_nxt = '0;
            if (pcnt < code_act) begin
              state_nxt = ST_PULSE;
              pcnt_nxt  = pcnt + 4'd1;
            end else begin
              state_nxt = ST_TAIL;
            end
          end else begin
            sp_nxt = sp_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    cmp_nxt = (state_nxt == ST_PULSE);
  end

  assign bus.cmp_out  = cmp_q;
  assign bus.set_out  = set_q;
  assign bus.busy     = busy_q;
  assign bus.code_act = code_act;

endmodule

// File: tb/tb_distinguish_pulse_gen.sv
// tb/tb_distinguish_pulse_gen.sv - vector table, scenario and randomized checks of distinguish_pulse_gen
module tb_distinguish_pulse_gen;

  localparam int W  = 1000;
  localparam int S  = 50;
  localparam int PW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  distinguish_pulse_gen_if bus ();

  distinguish_pulse_gen #(.WINDOW_CYCLES(W), .SPACING(S), .PULSE_WIDTH(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference: window position and code from the rules, pulses by arithmetic
  bit       m_run;
  int       m_win;
  int       m_code;
  int       m_pend;
  bit       e_cmp, e_set, e_busy;

  bit       rec;
  int       t;
  bit       prev_cmp;
  int       starts[$];
  int       sets[$];

  typedef struct {
    logic       en;
    logic       load;
    logic [3:0] code;
    logic       x_cmp;
    logic       x_set;
    logic       x_busy;
    logic [3:0] x_code;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_run = 0; m_win = 0; m_code = 0; m_pend = 0;
  endtask

  task automatic model_step(input logic e, input logic l, input logic [3:0] c);
    int pn;
    pn = l ? int'(c) : m_pend;
    if (!e) begin
      m_run = 0;
      m_win = 0;
    end else begin
      if (!m_run || m_win == W - 1) begin
        m_win  = 0;
        m_code = pn;
      end else begin
        m_win++;
      end
      m_run = 1;
    end
    m_pend = pn;
    e_cmp  = e && (m_win < m_code * S) && ((m_win % S) < PW);
    e_set  = e && (m_win == W - 1);
    e_busy = e;
  endtask

  task automatic tick(input logic e, input logic l, input logic [3:0] c);
    @(negedge clk);
    bus.en = e; bus.load = l; bus.code_in = c;
    @(posedge clk);
    model_step(e, l, c);
    #1;
    check("cmp_out",  int'(bus.cmp_out),  int'(e_cmp));
    check("set_out",  int'(bus.set_out),  int'(e_set));
    check("busy",     int'(bus.busy),     int'(e_busy));
    check("code_act", int'(bus.code_act), m_code);
    if (rec) begin
      if (bus.cmp_out && !prev_cmp) starts.push_back(t);
      if (bus.set_out) sets.push_back(t);
      prev_cmp = bus.cmp_out;
      t++;
    end
  endtask

  task automatic start_rec();
    starts.delete(); sets.delete();
    t = 0; prev_cmp = 0; rec = 1;
  endtask

  task automatic count_range(input int lo, input int hi, output int n);
    n = 0;
    foreach (starts[i]) if (starts[i] >= lo && starts[i] < hi) n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.en = 0; bus.load = 0; bus.code_in = 0;
    rst_n = 0;
    model_reset();
    #1;
    check("rst cmp_out", int'(bus.cmp_out), 0);
    check("rst set_out", int'(bus.set_out), 0);
    check("rst busy", int'(bus.busy), 0);
    check("rst code_act", int'(bus.code_act), 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  vec_t vt[8];
  int n;

  initial begin
    bus.en = 0; bus.load = 0; bus.code_in = 0;
    rec = 0;
    model_reset();
    #2 rst_n = 0;
    #1;
    check("async rst cmp_out", int'(bus.cmp_out), 0);
    check("async rst busy", int'(bus.busy), 0);
    check("async rst code_act", int'(bus.code_act), 0);
    check("async rst set_out", int'(bus.set_out), 0);
    do_reset();

    vt[0] = '{1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[1] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd5};
    vt[2] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd5};
    vt[3] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd5};
    vt[4] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd0};
    vt[5] = '{1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 4'd0};
    vt[6] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0};
    vt[7] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd2};
    for (int i = 0; i < 8; i++) begin
      tick(vt[i].en, vt[i].load, vt[i].code);
      check($sformatf("vec%0d cmp", i), int'(bus.cmp_out), int'(vt[i].x_cmp));
      check($sformatf("vec%0d set", i), int'(bus.set_out), int'(vt[i].x_set));
      check($sformatf("vec%0d busy", i), int'(bus.busy), int'(vt[i].x_busy));
      check($sformatf("vec%0d code", i), int'(bus.code_act), int'(vt[i].x_code));
    end

    // code 5: pulses at 0,50,..,200, set at 999
    do_reset();
    tick(0, 1, 5);
    start_rec();
    repeat (W) tick(1, 0, 0);
    check("c5 pulse count", starts.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < starts.size()) check($sformatf("c5 start%0d", k), starts[k], k * S);
    check("c5 set count", sets.size(), 1);
    if (sets.size() > 0) check("c5 set pos", sets[0], W - 1);

    // code 15 over three windows
    tick(0, 1, 15);
    start_rec();
    repeat (3 * W) tick(1, 0, 0);
    check("c15 pulse count", starts.size(), 45);
    if (starts.size() > 14) check("c15 last start", starts[14], 700);
    check("c15 set count", sets.size(), 3);

    // code 0: no pulses, sets every window
    tick(0, 1, 0);
    start_rec();
    repeat (3 * W) tick(1, 0, 0);
    check("c0 pulse count", starts.size(), 0);
    check("c0 set count", sets.size(), 3);
    for (int k = 0; k < 3; k++)
      if (k < sets.size()) check($sformatf("c0 set%0d", k), sets[k], k * W + W - 1);

    // mid-window load only takes effect at the wrap
    tick(0, 1, 7);
    start_rec();
    for (int i = 0; i < 2 * W; i++) begin
      tick(1, i == 400, 4'd3);
      if (i == W - 1) check("late load code@999", int'(bus.code_act), 7);
      if (i == W) check("late load code@1000", int'(bus.code_act), 3);
    end
    count_range(0, W, n);     check("late load win0 pulses", n, 7);
    count_range(W, 2 * W, n); check("late load win1 pulses", n, 3);

    // load in the wrap cycle is forwarded
    tick(0, 1, 3);
    start_rec();
    for (int i = 0; i < 2 * W; i++) tick(1, i == W, 4'd9);
    count_range(0, W, n);     check("wrap load win0 pulses", n, 3);
    count_range(W, 2 * W, n); check("wrap load win1 pulses", n, 9);

    // en drop mid-window, then restart
    tick(0, 1, 6);
    start_rec();
    repeat (120) tick(1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0);
      check("en low cmp", int'(bus.cmp_out), 0);
      check("en low busy", int'(bus.busy), 0);
      check("en low set", int'(bus.set_out), 0);
    end
    start_rec();
    repeat (W) tick(1, 0, 0);
    check("restart pulse count", starts.size(), 6);
    if (starts.size() > 0) check("restart first start", starts[0], 0);
    rec = 0;

    // asynchronous reset while cmp_out is high
    tick(0, 1, 4);
    tick(1, 0, 0);
    check("pre-reset cmp high", int'(bus.cmp_out), 1);
    #2 rst_n = 0;
    model_reset();
    #1;
    check("mid-pulse rst cmp", int'(bus.cmp_out), 0);
    check("mid-pulse rst busy", int'(bus.busy), 0);
    check("mid-pulse rst code", int'(bus.code_act), 0);
    @(negedge clk);
    rst_n = 1;
    tick(1, 0, 0);

    // randomized bursts against the reference
    for (int seg = 0; seg < 8; seg++) begin
      int len;
      len = $urandom_range(50, 1500);
      for (int i = 0; i < len; i++)
        tick(1'b1, ($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(1, 3))
        tick(1'b0, ($urandom_range(0, 1) == 0), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
